// File: rtl/serial_to_parallel.sv
`default_nettype none
// ============================================================================
// Module      : serial_to_parallel
// Description : SD host CMD-line deserializer. Shifts in WIDTH bits MSB first
//               after a one-cycle arm strobe, then presents the word and
//               pulses finished. Optional start-bit hunting is enabled with
//               `define SERIAL_TO_PARALLEL_START_BIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_to_parallel #(
  parameter int WIDTH = 48,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic             start_listening_nxt_cycle,
  input  logic             serial_in,
  output logic             finished,
  output logic [WIDTH-1:0] parallel_out
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_shift = 2'd1;
  localparam logic [1:0] c_st_done  = 2'd2;
`ifdef SERIAL_TO_PARALLEL_START_BIT_EN
  localparam logic [1:0] c_st_hunt  = 2'd3;
  localparam logic [1:0] c_st_armed = c_st_hunt;
`else
  localparam logic [1:0] c_st_armed = c_st_shift;
`endif

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  generate
    if (WIDTH < 2 || (2 ** CNT_W) <= WIDTH) begin : g_bad_params
      $error("serial_to_parallel: need WIDTH >= 2 and 2**CNT_W > WIDTH");
    end
  endgenerate

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  // Only WIDTH-1 bits are stored; the final bit goes straight to parallel_out.
  logic [WIDTH-2:0] r_shreg;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_word;
  logic             w_last;

  assign w_word = {r_shreg, serial_in};
  assign w_last = (r_cnt == c_cnt_last);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (start_listening_nxt_cycle) w_state_nxt = c_st_armed;
      end
`ifdef SERIAL_TO_PARALLEL_START_BIT_EN
      c_st_hunt: begin
        if (!serial_in) w_state_nxt = c_st_shift;
      end
`endif
      c_st_shift: begin
        if (w_last) w_state_nxt = c_st_done;
      end
      c_st_done: begin
        w_state_nxt = start_listening_nxt_cycle ? c_st_armed : c_st_idle;
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      r_state      <= c_st_idle;
      r_shreg      <= '0;
      r_cnt        <= '0;
      parallel_out <= '0;
      finished     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      finished <= (r_state == c_st_shift) && w_last;
      case (r_state)
        c_st_idle, c_st_done: begin
          if (start_listening_nxt_cycle) r_cnt <= '0;
        end
`ifdef SERIAL_TO_PARALLEL_START_BIT_EN
        // The start bit itself is frame bit WIDTH-1.
        c_st_hunt: begin
          if (!serial_in) begin
            r_shreg <= w_word[WIDTH-2:0];
            r_cnt   <= c_cnt_one;
          end
        end
`endif
        c_st_shift: begin
          r_shreg <= w_word[WIDTH-2:0];
          r_cnt   <= r_cnt + c_cnt_one;
          if (w_last) parallel_out <= w_word;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_to_parallel.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_to_parallel
// Description : Directed self-checking bench for serial_to_parallel.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_to_parallel;

  logic        CLK = 1'b0;
  logic        RESET_L;
  logic        strobe;
  logic        serial_in;
  logic        finished;
  logic [47:0] parallel_out;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int fin_count = 0;
  int arm_cyc = 0;
  int fin1 = 0;
  int f0 = 0;

  serial_to_parallel #(.WIDTH(48), .CNT_W(6)) u_dut (
    .CLK                       (CLK),
    .RESET_L                   (RESET_L),
    .start_listening_nxt_cycle (strobe),
    .serial_in                 (serial_in),
    .finished                  (finished),
    .parallel_out              (parallel_out)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (finished === 1'b1) fin_count <= fin_count + 1;
  end

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic arm();
    strobe = 1'b1;
    @(negedge CLK);
    strobe  = 1'b0;
    arm_cyc = cyc;
  endtask

  // Drives 48 bits MSB first; optionally pulses the strobe mid-frame.
  task automatic shift_bits(input logic [47:0] w, input logic [47:0] hold_exp, input bit glitch);
    for (int i = 47; i >= 0; i--) begin
      serial_in = w[i];
      if (glitch) strobe = (i == 30);
      if (i == 24) begin
        check("hold_mid", parallel_out, hold_exp);
        check("fin_mid", {47'd0, finished}, 48'd1 - 48'd1);
      end
      if (i == 0) check("fin_before_last", {47'd0, finished}, 48'd0);
      @(negedge CLK);
    end
    serial_in = 1'b0;
    strobe    = 1'b0;
  endtask

  task automatic expect_done(input string tag, input logic [47:0] w);
    check({tag, "_fin"}, {47'd0, finished}, 48'd1);
    check({tag, "_data"}, parallel_out, w);
    check({tag, "_lat"}, 48'(cyc - arm_cyc), 48'd48);
  endtask

  initial begin
    RESET_L   = 1'b0;
    strobe    = 1'b0;
    serial_in = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_out", parallel_out, 48'd0);
    check("rst_fin", {47'd0, finished}, 48'd0);
    RESET_L = 1'b1;
    repeat (10) @(negedge CLK);
    check("idle_out", parallel_out, 48'd0);
    check("idle_pulses", 48'(fin_count), 48'd0);

`ifndef SERIAL_TO_PARALLEL_START_BIT_EN
    // All ones, with a stray strobe mid-frame that must be ignored.
    arm();
    shift_bits(48'hFFFF_FFFF_FFFF, 48'd0, 1'b1);
    expect_done("ones", 48'hFFFF_FFFF_FFFF);
    f0 = fin_count;
    @(negedge CLK);
    check("ones_fin_low", {47'd0, finished}, 48'd0);
    check("ones_pulses", 48'(fin_count - f0), 48'd1);

    // Alternating pattern, then a back-to-back all-zero frame.
    repeat (2) @(negedge CLK);
    arm();
    shift_bits(48'hAAAA_AAAA_AAAA, 48'hFFFF_FFFF_FFFF, 1'b0);
    expect_done("alt", 48'hAAAA_AAAA_AAAA);
    fin1 = cyc;
    arm();
    shift_bits(48'd0, 48'hAAAA_AAAA_AAAA, 1'b0);
    expect_done("b2b", 48'd0);
    check("b2b_gap", 48'(cyc - fin1), 48'd49);

    // Load a nonzero word, then reset partway through the next frame.
    @(negedge CLK);
    arm();
    shift_bits(48'h1234_5678_9ABC, 48'd0, 1'b0);
    expect_done("frm3", 48'h1234_5678_9ABC);
    @(negedge CLK);
    arm();
    serial_in = 1'b1;
    repeat (20) @(negedge CLK);
    RESET_L = 1'b0;
    #1;
    check("midrst_out", parallel_out, 48'd0);
    check("midrst_fin", {47'd0, finished}, 48'd0);
    repeat (2) @(negedge CLK);
    RESET_L   = 1'b1;
    serial_in = 1'b0;
    f0 = fin_count;
    repeat (30) @(negedge CLK);
    check("midrst_pulses", 48'(fin_count - f0), 48'd0);
    check("midrst_hold", parallel_out, 48'd0);
    arm();
    shift_bits(48'h8000_0000_0001, 48'd0, 1'b0);
    expect_done("postrst", 48'h8000_0000_0001);
`else
    // Five idle-high bits precede the start bit.
    arm();
    serial_in = 1'b1;
    repeat (5) @(negedge CLK);
    shift_bits(48'h3FFF_0000_1235, 48'd0, 1'b0);
    check("sb_fin", {47'd0, finished}, 48'd1);
    check("sb_data", parallel_out, 48'h3FFF_0000_1235);
    check("sb_lat", 48'(cyc - arm_cyc), 48'd53);
    f0 = fin_count;
    @(negedge CLK);
    check("sb_fin_low", {47'd0, finished}, 48'd0);
    check("sb_pulses", 48'(fin_count - f0), 48'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_to_parallel.md
Name: serial_to_parallel

Overview:
- Deserializer for the SD host CMD path. Converts the serial CMD-line response bitstream into one parallel 48-bit response word.
- The command FSM arms it with a one-cycle strobe. It shifts in WIDTH bits, MSB first, then presents the word and pulses `finished`.
- Sits between the CMD pad input and the response decoder / CRC checker.

Parameters:
- WIDTH, 48, number of bits per frame and width of `parallel_out` (minimum 2).
- CNT_W, 6, bit counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET_L  input  1  asynchronous active-low reset.
- start_listening_nxt_cycle  input  1  arm strobe; the first data bit is sampled on the edge after the one that samples this high.
- serial_in  input  1  serial CMD-line data, MSB first, stable around the rising edge.
- finished  output  1  one-cycle pulse: frame complete, `parallel_out` valid.
- parallel_out  output  WIDTH  last completed frame; bit WIDTH-1 is the first bit received.

Behaviour:
- Interface (already decided): one clock, CLK. Reset RESET_L is asynchronous and active-low.
- Reset (RESET_L low, asynchronous): state IDLE; shift register, counter and `parallel_out` all zero; `finished` 0.
- IDLE:
  - Edge with start_listening_nxt_cycle=1 goes to SHIFT and clears the counter.
  - serial_in is not sampled on this edge.
- SHIFT: each edge does shreg <= {shreg[WIDTH-2:0], serial_in} and counter+1.
- Last bit: on the edge capturing bit number WIDTH (counter == WIDTH-1):
  - `parallel_out` <= completed word, including that last bit.
  - `finished` <= 1.
  - Go to DONE.
- Latency: strobe sampled at edge N; bits sampled at edges N+1 through N+WIDTH; `finished` high for exactly the cycle after edge N+WIDTH.
- DONE (one cycle, `finished`=1):
  - Strobe high here goes to SHIFT (back-to-back frames allowed; bit 1 is sampled on the following edge).
  - Otherwise return to IDLE.
- `finished` is registered, never combinational. It is low in every state except DONE.
- `parallel_out` changes only at frame completion or reset. It holds its value indefinitely and never shows a partial frame.
- Strobe asserted during SHIFT is ignored. The current frame continues unaffected.
- Strobe held high continuously: frames repeat back-to-back, one DONE cycle between them.
- Reset mid-frame: the partial frame is discarded. `parallel_out` clears to 0 and no `finished` is issued.
- serial_in is treated as already synchronized; no internal synchronizer.

Optional Feature:
- Macro: SERIAL_TO_PARALLEL_START_BIT_EN.
- Defined:
  - After the arm edge, state is HUNT, not SHIFT.
  - HUNT samples serial_in each edge. The first 0 (SD start bit) is captured as bit WIDTH-1 and the block moves to SHIFT with counter=1.
  - Strobe is ignored while in HUNT.
  - Total latency becomes (edges spent in HUNT) + WIDTH.
- Undefined: no HUNT state; counting starts unconditionally as described above.

Test Plan:
- Reset then idle: RESET_L low, then high for 10 cycles with strobe=0 -> parallel_out=0, finished never 1.
- All-ones frame: strobe 1 for one cycle, serial_in=1 for 48 cycles -> finished pulses exactly once, one cycle after the 48th sampling edge; parallel_out=48'hFFFF_FFFF_FFFF.
- Pattern frame: serial_in = 1,0,1,0,... for 48 bits -> parallel_out=48'hAAAA_AAAA_AAAA; the first bit lands in bit 47.
- Back-to-back: strobe high during DONE, second frame all zeros -> second finished exactly 49 cycles after the first; parallel_out goes from 48'hAAAA_AAAA_AAAA to 0 only at the second finished.
- Reset mid-frame: RESET_L low after 20 bits -> parallel_out=0 immediately, no finished; a new strobe then captures a clean 48-bit frame.
- Start-bit build (macro defined): strobe, then 5 cycles of 1, then 48'h3FFF_0000_1235 (starts with 0) -> parallel_out=48'h3FFF_0000_1235, finished 53 cycles after the arm edge.
